// File: rtl/uart_pkg.sv
// uart_pkg
// Shared definitions for the UART receive path: receiver state encoding,
// frame geometry and the default bit timing (9600 baud at 100 MHz).
package uart_pkg;

    typedef enum logic [2:0] {
        IDLE,
        START,
        DATA,
        STOP,
        WAIT_HIGH
    } rx_state_t;

    localparam int DATA_BITS            = 8;
    localparam int CLKS_PER_BIT_DEFAULT = 10416;

    localparam logic START_BIT = 1'b0;
    localparam logic STOP_BIT  = 1'b1;

endpackage

// File: rtl/uart_rx_sync.sv
// uart_rx_sync
// Two-flop synchroniser for asynchronous inputs. Both stages reset to 1,
// which matches an idle-high serial line, so a reset never looks like a
// start bit.
// Ports:
//   clk  - system clock
//   rst  - synchronous active-high reset
//   d    - asynchronous input
//   q    - synchronised output (2 cycles of latency)
module uart_rx_sync #(
    parameter int WIDTH = 1
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [WIDTH-1:0] d,
    output logic [WIDTH-1:0] q
);

    logic [WIDTH-1:0] meta;

    always_ff @(posedge clk) begin
        if (rst) begin
            meta <= '1;
            q    <= '1;
        end else begin
            meta <= d;
            q    <= meta;
        end
    end

endmodule

// File: rtl/uart_receiver.sv
// uart_receiver
// 8N1 UART receive stage. The line is synchronised, the start bit is
// re-checked at mid-bit, each data bit is sampled at its centre (LSB first)
// and the stop bit is checked. A good frame updates data with a one-cycle
// data_valid pulse; a bad stop bit gives a one-cycle framing_error pulse
// and the receiver then waits for the line to return high.
//
// state     | meaning
// ----------+-------------------------------------------------------
// IDLE      | line idle, waiting for a falling edge on rxd_s
// START     | timing half a bit to confirm the start bit
// DATA      | sampling 8 data bits, one per bit period
// STOP      | sampling the stop bit
// WAIT_HIGH | stop bit was 0 (break); hold until the line goes high
//
// Ports:
//   clk           - system clock
//   rst           - synchronous active-high reset
//   rxd           - asynchronous serial line, idle high
//   data          - last correctly received byte
//   data_valid    - one-cycle pulse when data is updated
//   framing_error - one-cycle pulse when the stop bit sampled 0
//   busy          - high whenever the receiver is not idle
module uart_receiver
    import uart_pkg::*;
#(
    parameter int CLKS_PER_BIT = CLKS_PER_BIT_DEFAULT
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       rxd,
    output logic [7:0] data,
    output logic       data_valid,
    output logic       framing_error,
    output logic       busy
);

    localparam int HALF_BIT = CLKS_PER_BIT / 2;
    localparam int CW       = $clog2(CLKS_PER_BIT);

    localparam logic [CW-1:0] BIT_LAST  = CW'(CLKS_PER_BIT - 1);
    localparam logic [CW-1:0] HALF_LAST = CW'(HALF_BIT - 1);
    localparam logic [2:0]    IDX_LAST  = 3'(DATA_BITS - 1);

    logic rxd_s;

    rx_state_t              state, state_n;
    logic [CW-1:0]          bit_clk, bit_clk_n;
    logic [2:0]             bit_idx, bit_idx_n;
    logic [DATA_BITS-1:0]   shift_reg, shift_n;
    logic [DATA_BITS-1:0]   data_n;
    logic                   data_valid_n;
    logic                   framing_error_n;

    uart_rx_sync #(.WIDTH(1)) u_sync (
        .clk (clk),
        .rst (rst),
        .d   (rxd),
        .q   (rxd_s)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            state         <= IDLE;
            bit_clk       <= '0;
            bit_idx       <= '0;
            shift_reg     <= '0;
            data          <= '0;
            data_valid    <= 1'b0;
            framing_error <= 1'b0;
        end else begin
            state         <= state_n;
            bit_clk       <= bit_clk_n;
            bit_idx       <= bit_idx_n;
            shift_reg     <= shift_n;
            data          <= data_n;
            data_valid    <= data_valid_n;
            framing_error <= framing_error_n;
        end
    end

    always_comb begin
        state_n         = state;
        bit_clk_n       = bit_clk;
        bit_idx_n       = bit_idx;
        shift_n         = shift_reg;
        data_n          = data;
        data_valid_n    = 1'b0;
        framing_error_n = 1'b0;

        case (state)
            IDLE: begin
                if (rxd_s == START_BIT) begin
                    state_n   = START;
                    bit_clk_n = '0;
                end
            end

            START: begin
                if (bit_clk == HALF_LAST) begin
                    bit_clk_n = '0;
                    if (rxd_s == START_BIT) begin
                        state_n   = DATA;
                        bit_idx_n = '0;
                    end else begin
                        // Line went back high before mid-bit: a glitch.
                        state_n = IDLE;
                    end
                end else begin
                    bit_clk_n = bit_clk + CW'(1);
                end
            end

            DATA: begin
                if (bit_clk == BIT_LAST) begin
                    bit_clk_n = '0;
                    shift_n   = {rxd_s, shift_reg[DATA_BITS-1:1]};
                    if (bit_idx == IDX_LAST) begin
                        state_n = STOP;
                    end else begin
                        bit_idx_n = bit_idx + 3'd1;
                    end
                end else begin
                    bit_clk_n = bit_clk + CW'(1);
                end
            end

            STOP: begin
                if (bit_clk == BIT_LAST) begin
                    bit_clk_n = '0;
                    // Returning to IDLE at the stop-bit centre lets a
                    // following start bit arrive up to half a bit early.
                    if (rxd_s == STOP_BIT) begin
                        data_n       = shift_reg;
                        data_valid_n = 1'b1;
                        state_n      = IDLE;
                    end else begin
                        framing_error_n = 1'b1;
                        state_n         = WAIT_HIGH;
                    end
                end else begin
                    bit_clk_n = bit_clk + CW'(1);
                end
            end

            WAIT_HIGH: begin
                if (rxd_s == STOP_BIT) begin
                    state_n = IDLE;
                end
            end

            default: begin
                state_n = IDLE;
            end
        endcase
    end

    assign busy = (state != IDLE);

endmodule

// File: tb/tb_uart_receiver.sv
module tb_uart_receiver;

    localparam int CPB = 16;

    logic       clk;
    logic       rst;
    logic       rxd;
    logic [7:0] data;
    logic       data_valid;
    logic       framing_error;
    logic       busy;

    typedef struct packed {
        logic       err;
        logic [7:0] data;
    } exp_t;

    exp_t exp_q[$];
    int   n_cmp = 0;
    int   n_bad = 0;

    uart_receiver #(.CLKS_PER_BIT(CPB)) dut (
        .clk           (clk),
        .rst           (rst),
        .rxd           (rxd),
        .data          (data),
        .data_valid    (data_valid),
        .framing_error (framing_error),
        .busy          (busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Monitor: every strobe must match the head of the expectation queue.
    always @(negedge clk) begin
        exp_t e;
        if (!rst && (data_valid || framing_error)) begin
            n_cmp++;
            if (data_valid && framing_error) begin
                n_bad++;
                $display("FAIL strobe_excl: data_valid=1 framing_error=1 both high");
            end else if (exp_q.size() == 0) begin
                n_bad++;
                $display("FAIL unexpected_strobe: dv=%0b fe=%0b data=%02h, none required",
                         data_valid, framing_error, data);
            end else begin
                e = exp_q.pop_front();
                if (framing_error !== e.err || data !== e.data) begin
                    n_bad++;
                    $display("FAIL strobe_check: got fe=%0b data=%02h, required fe=%0b data=%02h",
                             framing_error, data, e.err, e.data);
                end
            end
        end
    end

    task automatic check(input string name, input logic [7:0] act, input logic [7:0] req);
        n_cmp++;
        if (act !== req) begin
            n_bad++;
            $display("FAIL %s: got %02h, required %02h", name, act, req);
        end
    endtask

    task automatic drive_bit(input logic b);
        rxd = b;
        repeat (CPB) @(negedge clk);
    endtask

    task automatic send_frame(input logic [7:0] b, input logic stop);
        drive_bit(1'b0);
        for (int i = 0; i < 8; i++) drive_bit(b[i]);
        drive_bit(stop);
    endtask

    task automatic push(input logic err, input logic [7:0] d);
        exp_t e;
        e.err  = err;
        e.data = d;
        exp_q.push_back(e);
    endtask

    task automatic drain(input string name);
        for (int i = 0; i < 30 * CPB && exp_q.size() != 0; i++) @(negedge clk);
        if (exp_q.size() != 0) begin
            n_cmp++;
            n_bad++;
            $display("FAIL %s: timeout, %0d strobes outstanding, required 0", name, exp_q.size());
            exp_q.delete();
        end
    endtask

    initial begin
        rxd = 1'b1;
        rst = 1'b1;
        repeat (3) @(negedge clk);
        check("rst_data", data, 8'h00);
        check("rst_dv", {7'd0, data_valid}, 8'h00);
        check("rst_fe", {7'd0, framing_error}, 8'h00);
        check("rst_busy", {7'd0, busy}, 8'h00);
        rst = 1'b0;
        repeat (4) @(negedge clk);

        // Ideal frame
        push(1'b0, 8'hA5);
        send_frame(8'hA5, 1'b1);
        drain("frame_a5");
        repeat (2) @(negedge clk);
        check("busy_after_a5", {7'd0, busy}, 8'h00);

        // Back-to-back, no idle gap
        push(1'b0, 8'h00);
        push(1'b0, 8'hFF);
        send_frame(8'h00, 1'b1);
        send_frame(8'hFF, 1'b1);
        drain("b2b");

        // Short glitch shorter than half a bit
        rxd = 1'b0;
        repeat (4) @(negedge clk);
        rxd = 1'b1;
        repeat (10) @(negedge clk);
        check("busy_after_glitch", {7'd0, busy}, 8'h00);
        push(1'b0, 8'h3C);
        send_frame(8'h3C, 1'b1);
        drain("frame_3c");

        // Framing error followed by a break
        push(1'b1, 8'h3C);
        send_frame(8'h55, 1'b0);
        repeat (40) @(negedge clk);
        check("busy_in_break", {7'd0, busy}, 8'h01);
        check("data_held_fe", data, 8'h3C);
        drain("framing_err");
        rxd = 1'b1;
        repeat (6) @(negedge clk);
        check("busy_after_break", {7'd0, busy}, 8'h00);
        push(1'b0, 8'h81);
        send_frame(8'h81, 1'b1);
        drain("frame_81");

        // Reset in the middle of bit 4 of 0xC3
        drive_bit(1'b0);
        for (int i = 0; i < 4; i++) drive_bit(1'(8'hC3 >> i));
        rxd = 1'b0;
        repeat (CPB / 2) @(negedge clk);
        rxd = 1'b1;
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        check("midrst_data", data, 8'h00);
        check("midrst_dv", {7'd0, data_valid}, 8'h00);
        check("midrst_fe", {7'd0, framing_error}, 8'h00);
        check("midrst_busy", {7'd0, busy}, 8'h00);
        repeat (2 * CPB) @(negedge clk);
        check("busy_idle_after_rst", {7'd0, busy}, 8'h00);
        push(1'b0, 8'h18);
        send_frame(8'h18, 1'b1);
        drain("frame_18");
        repeat (2 * CPB) @(negedge clk);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
